// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
// State encoding and the per-stage enable/flush bundle.
package hazard_stall_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic exmem_flush;
    logic memwb_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_write:     1'b1,
    ifid_write:   1'b1,
    ifid_flush:   1'b0,
    idex_write:   1'b1,
    idex_flush:   1'b0,
    exmem_write:  1'b1,
    exmem_flush:  1'b0,
    memwb_bubble: 1'b0
  };

  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_write:     1'b0,
    ifid_write:   1'b0,
    ifid_flush:   1'b0,
    idex_write:   1'b0,
    idex_flush:   1'b0,
    exmem_write:  1'b0,
    exmem_flush:  1'b0,
    memwb_bubble: 1'b1
  };

  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_write:     1'b0,
    ifid_write:   1'b0,
    ifid_flush:   1'b1,
    idex_write:   1'b0,
    idex_flush:   1'b1,
    exmem_write:  1'b0,
    exmem_flush:  1'b1,
    memwb_bubble: 1'b1
  };

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs from the stages and enables/status back to them.
// Master drives hazard inputs; slave is the controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_stall_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rt;
  logic             pcSrc;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output idex_memread, idex_rt,
    output pcSrc, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_write, idex_flush,
    input  exmem_write, exmem_flush,
    input  memwb_bubble, mem_err,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  idex_memread, idex_rt,
    input  pcSrc, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush,
    output idex_write, idex_flush,
    output exmem_write, exmem_flush,
    output memwb_bubble, mem_err,
    output stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count qualifying cycles, sticking at the top value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch
// flushes, data-memory waits with watchdog, perf counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_stall_ctrl_if.slave    bus
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_nxt;
  logic             r_mem_err;
  logic             w_err_nxt;
  logic             w_lu;
  logic             w_flush_inc;
  logic             w_stall_inc;
  pipe_ctrl_t       w_ctrl;
  pipe_ctrl_t       w_out;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  // Load-use: lw in EX writes a register the ID instr reads.
  always_comb begin
    w_lu = bus.idex_memread
         && (bus.idex_rt != '0)
         && ((bus.idex_rt == bus.id_rs)
          || (bus.id_uses_rt && (bus.idex_rt == bus.id_rt)));
  end

  // State, watchdog count and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_mem_err  <= w_err_nxt;
    end
  end

  // Next state and Mealy pipeline controls.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_mem_err;
    w_ctrl      = CTRL_RUN;
    w_flush_inc = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.pcSrc) begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_flush  = 1'b1;
          w_ctrl.exmem_flush = 1'b1;
          w_flush_inc        = 1'b1;
        end else if (bus.mem_req && !bus.mem_ready) begin
          w_ctrl      = CTRL_FREEZE;
          w_wait_nxt  = WC_W'(1);
          w_state_nxt = ST_MEM_WAIT;
        end else if (w_lu) begin
          w_ctrl.pc_write   = 1'b0;
          w_ctrl.ifid_write = 1'b0;
          w_ctrl.idex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          w_wait_nxt  = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_ctrl = CTRL_FREEZE;
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + WC_W'(1);
          end
        end
      end
      ST_ERR: begin
        w_ctrl = CTRL_FREEZE;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Stalls count only while the pipe is alive, not in ERR.
  always_comb begin
    w_stall_inc = (r_state != ST_ERR) && !w_ctrl.pc_write;
  end

  // Reset forces every stage to hold a bubble.
  always_comb begin
    w_out = rst ? CTRL_RESET : w_ctrl;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall_inc),
    .o_count (w_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_flush_inc),
    .o_count (w_flush_cnt)
  );

  assign bus.pc_write     = w_out.pc_write;
  assign bus.ifid_write   = w_out.ifid_write;
  assign bus.ifid_flush   = w_out.ifid_flush;
  assign bus.idex_write   = w_out.idex_write;
  assign bus.idex_flush   = w_out.idex_flush;
  assign bus.exmem_write  = w_out.exmem_write;
  assign bus.exmem_flush  = w_out.exmem_flush;
  assign bus.memwb_bubble = w_out.memwb_bubble;
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cycles = w_stall_cnt;
  assign bus.flush_count  = w_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=3).
// Control bits: {pc,ifid_w,ifid_f,idex_w,idex_f,exm_w,exm_f,bub}.
module tb_hazard_stall_ctrl;

  localparam logic [7:0] C_DEF = 8'b1101_0100;
  localparam logic [7:0] C_LU  = 8'b0001_1100;
  localparam logic [7:0] C_BR  = 8'b1111_1110;
  localparam logic [7:0] C_FRZ = 8'b0000_0001;
  localparam logic [7:0] C_RST = 8'b0010_1011;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       mr;
    logic [4:0] exrt;
    logic       pc;
    logic       rq;
    logic       rd;
    logic [7:0] ctrl;
    logic       err;
    logic [2:0] st;
    logic [2:0] fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  hazard_stall_ctrl_if #(.CNT_W(3)) bus ();

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input string n,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic ur, input logic mr, input logic [4:0] exrt,
    input logic pc, input logic rq, input logic rd,
    input logic [7:0] ctrl, input logic err,
    input logic [2:0] st, input logic [2:0] fl);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.ur = ur;
    v.mr = mr; v.exrt = exrt; v.pc = pc; v.rq = rq;
    v.rd = rd; v.ctrl = ctrl; v.err = err;
    v.st = st; v.fl = fl;
    return v;
  endfunction

  function automatic logic [7:0] ctrl_now();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
            bus.idex_write, bus.idex_flush, bus.exmem_write,
            bus.exmem_flush, bus.memwb_bubble};
  endfunction

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.idex_memread = 1'b0; bus.idex_rt = '0;
    bus.pcSrc = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_uses_rt = v.ur;
    bus.idex_memread = v.mr; bus.idex_rt = v.exrt;
    bus.pcSrc = v.pc; bus.mem_req = v.rq; bus.mem_ready = v.rd;
    #1;
    chk({v.name, ".ctrl"}, ctrl_now(), v.ctrl);
    chk({v.name, ".err"}, {7'd0, bus.mem_err}, {7'd0, v.err});
    chk({v.name, ".stall"}, {5'd0, bus.stall_cycles}, {5'd0, v.st});
    chk({v.name, ".flush"}, {5'd0, bus.flush_count}, {5'd0, v.fl});
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0);
    tbl[1]  = mk("lu_rs",     8, 0, 0, 1, 8, 0, 0, 0, C_LU,  0, 0, 0);
    tbl[2]  = mk("post_lu",   0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 1, 0);
    tbl[3]  = mk("lu_r0",     0, 0, 0, 1, 0, 0, 0, 0, C_DEF, 0, 1, 0);
    tbl[4]  = mk("lu_rt",     3, 9, 1, 1, 9, 0, 0, 0, C_LU,  0, 1, 0);
    tbl[5]  = mk("rt_unused", 3, 9, 0, 1, 9, 0, 0, 0, C_DEF, 0, 2, 0);
    tbl[6]  = mk("br_lu",     8, 0, 0, 1, 8, 1, 0, 0, C_BR,  0, 2, 0);
    tbl[7]  = mk("post_br",   0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 2, 1);
    tbl[8]  = mk("br_req",    0, 0, 0, 0, 0, 1, 1, 0, C_BR,  0, 2, 1);
    tbl[9]  = mk("req_rdy",   0, 0, 0, 0, 0, 0, 1, 1, C_DEF, 0, 2, 2);
    tbl[10] = mk("mw1",       0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 2, 2);
    tbl[11] = mk("mw2_lu",    8, 0, 0, 1, 8, 0, 1, 0, C_FRZ, 0, 3, 2);
    tbl[12] = mk("mw3",       0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 4, 2);
    tbl[13] = mk("mw_rdy4",   0, 0, 0, 0, 0, 0, 1, 1, C_DEF, 0, 5, 2);
    tbl[14] = mk("run_lu",    8, 0, 0, 1, 8, 0, 0, 0, C_LU,  0, 5, 2);
    tbl[15] = mk("idle_end",  0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 6, 2);

    drive_idle();
    #2;
    chk("rst_ctrl_async", ctrl_now(), C_RST);
    @(negedge clk);
    #1;
    chk("rst_ctrl", ctrl_now(), C_RST);
    chk("rst_err", {7'd0, bus.mem_err}, 8'd0);
    chk("rst_stall", {5'd0, bus.stall_cycles}, 8'd0);
    chk("rst_flush", {5'd0, bus.flush_count}, 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Watchdog: four unready cycles then a sticky ERR freeze.
    do_reset();
    run_vec(mk("to1", 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0));
    run_vec(mk("to2", 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 1, 0));
    run_vec(mk("to3", 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 2, 0));
    run_vec(mk("to4", 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 0));
    run_vec(mk("to_err", 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 4, 0));
    run_vec(mk("err_br", 0, 0, 0, 0, 0, 1, 1, 1, C_FRZ, 1, 4, 0));
    run_vec(mk("err_idle", 0, 0, 0, 0, 0, 0, 0, 0, C_FRZ, 1, 4, 0));

    // Flush counter saturates at 7.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_vec(mk($sformatf("sat%0d", i), 0, 0, 0, 0, 0, 1, 0, 0,
                 C_BR, 0, 0, 3'((i > 7) ? 7 : i)));
    end
    run_vec(mk("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 7));

    // Async reset pulse between edges while in MEM_WAIT.
    do_reset();
    run_vec(mk("ar_mw1", 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0));
    run_vec(mk("ar_mw2", 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 1, 0));
    #1;
    drive_idle();
    rst = 1'b1;
    #1;
    chk("ar_ctrl", ctrl_now(), C_RST);
    chk("ar_stall", {5'd0, bus.stall_cycles}, 8'd0);
    #1 rst = 1'b0;
    run_vec(mk("ar_run", 0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0));
    run_vec(mk("ar_lu", 8, 0, 0, 1, 8, 0, 0, 0, C_LU, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
